// File: rtl/bus_fifo_pkg.sv
// Shared width helpers for the multi-channel bus FIFO target.
package bus_fifo_pkg;

    function automatic int ch_width(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bus_fifo_channel.sv
// Single-channel FIFO: storage, wrapping pointers and occupancy count.
// The parent decides push/pop acceptance; this block just obeys the enables.
module bus_fifo_channel
    import bus_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/bus_fifo_target.sv
// Multi-channel bus FIFO target: request decode, registered read port and
// sticky overflow/underflow flags around NUM_CHANNELS independent FIFOs.
module bus_fifo_target
    import bus_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int NUM_CHANNELS = 2,
    localparam int CH_W        = ch_width(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write,
    input  logic [CH_W-1:0]         write_channel,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    read,
    input  logic [CH_W-1:0]         read_channel,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic [NUM_CHANNELS-1:0] full,
    output logic [NUM_CHANNELS-1:0] empty,
    output logic [NUM_CHANNELS-1:0] overflow,
    output logic [NUM_CHANNELS-1:0] underflow,
    input  logic                    error_clear
);

    logic [NUM_CHANNELS-1:0] wr_req;
    logic [NUM_CHANNELS-1:0] rd_req;
    logic [NUM_CHANNELS-1:0] push_en;
    logic [NUM_CHANNELS-1:0] pop_en;
    logic [NUM_CHANNELS-1:0] ovf_ev;
    logic [NUM_CHANNELS-1:0] unf_ev;
    logic [DATA_WIDTH-1:0]   ch_data [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   sel_data;

    // Out-of-range channel indices match no channel, so they are silently ignored.
    // A push to a full channel is accepted when the same channel pops this cycle.
    always_comb begin
        wr_req   = '0;
        rd_req   = '0;
        push_en  = '0;
        pop_en   = '0;
        ovf_ev   = '0;
        unf_ev   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            wr_req[i]  = write && (write_channel == CH_W'(i));
            rd_req[i]  = read && (read_channel == CH_W'(i));
            pop_en[i]  = rd_req[i] && !empty[i];
            unf_ev[i]  = rd_req[i] && empty[i];
            push_en[i] = wr_req[i] && (!full[i] || pop_en[i]);
            ovf_ev[i]  = wr_req[i] && !push_en[i];
            if (pop_en[i]) sel_data = ch_data[i];
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        bus_fifo_channel #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .push     (push_en[g]),
            .pop      (pop_en[g]),
            .push_data(write_data),
            .pop_data (ch_data[g]),
            .full     (full[g]),
            .empty    (empty[g])
        );
    end

    // A new error event in the same cycle as error_clear leaves its flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data  <= '0;
            read_valid <= 1'b0;
            overflow   <= '0;
            underflow  <= '0;
        end else begin
            read_valid <= |pop_en;
            if (|pop_en) read_data <= sel_data;
            overflow  <= (error_clear ? '0 : overflow) | ovf_ev;
            underflow <= (error_clear ? '0 : underflow) | unf_ev;
        end
    end

endmodule

// File: tb/tb_bus_fifo_target.sv
// Randomised scoreboard bench for bus_fifo_target against a queue-based model.
module tb_bus_fifo_target;
    import bus_fifo_pkg::*;

    localparam int DW   = 32;
    localparam int DEP  = 8;
    localparam int NC   = 2;
    localparam int CH_W = ch_width(NC);

    typedef struct packed {
        logic          rv;
        logic [DW-1:0] rd;
        logic [NC-1:0] full;
        logic [NC-1:0] empty;
        logic [NC-1:0] ovf;
        logic [NC-1:0] unf;
    } snap_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            write = 1'b0;
    logic [CH_W-1:0] write_channel = '0;
    logic [DW-1:0]   write_data = '0;
    logic            read = 1'b0;
    logic [CH_W-1:0] read_channel = '0;
    logic [DW-1:0]   read_data;
    logic            read_valid;
    logic [NC-1:0]   full, empty, overflow, underflow;
    logic            error_clear = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    snap_t         exp_q[$];
    logic [DW-1:0] mq [NC][$];
    logic [NC-1:0] m_ovf = '0, m_unf = '0;
    logic          m_rv = 1'b0;
    logic [DW-1:0] m_rd = '0;

    always #5 clk = ~clk;

    bus_fifo_target #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEP),
        .NUM_CHANNELS(NC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write        (write),
        .write_channel(write_channel),
        .write_data   (write_data),
        .read         (read),
        .read_channel (read_channel),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .error_clear  (error_clear)
    );

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    // Drive one cycle of inputs and advance the model to the post-edge state.
    task automatic step(input logic w, input int wc, input logic [DW-1:0] wd,
                        input logic r, input int rc, input logic clr, input logic rs);
        snap_t s;
        logic [NC-1:0] ovf_ev, unf_ev;
        logic rd_ok, wr_ok;
        @(negedge clk);
        write = w; write_channel = CH_W'(wc); write_data = wd;
        read = r; read_channel = CH_W'(rc); error_clear = clr; rst = rs;
        ovf_ev = '0;
        unf_ev = '0;
        if (rs) begin
            for (int c = 0; c < NC; c++) mq[c].delete();
            m_ovf = '0; m_unf = '0; m_rv = 1'b0; m_rd = '0;
        end else begin
            rd_ok = r && (rc < NC) && (mq[rc].size() > 0);
            wr_ok = w && (wc < NC) && ((mq[wc].size() < DEP) || (rd_ok && rc == wc));
            if (w && wc < NC && !wr_ok) ovf_ev[wc] = 1'b1;
            if (r && rc < NC && !rd_ok) unf_ev[rc] = 1'b1;
            m_ovf = (clr ? '0 : m_ovf) | ovf_ev;
            m_unf = (clr ? '0 : m_unf) | unf_ev;
            m_rv  = rd_ok;
            if (rd_ok) m_rd = mq[rc].pop_front();
            if (wr_ok) mq[wc].push_back(wd);
        end
        s.rv = m_rv;
        s.rd = m_rd;
        s.ovf = m_ovf;
        s.unf = m_unf;
        for (int c = 0; c < NC; c++) begin
            s.full[c]  = (mq[c].size() == DEP);
            s.empty[c] = (mq[c].size() == 0);
        end
        exp_q.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, '0, 0, 0, 0, 0);
    endtask

    // Monitor: one expected snapshot per driven cycle, compared just after the edge.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("read_valid", DW'(read_valid), DW'(e.rv));
                chk("read_data", read_data, e.rd);
                chk("full", DW'(full), DW'(e.full));
                chk("empty", DW'(empty), DW'(e.empty));
                chk("overflow", DW'(overflow), DW'(e.ovf));
                chk("underflow", DW'(underflow), DW'(e.unf));
            end
        end
    end

    initial begin
        int budget;
        step(0, 0, '0, 0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 0, 1);
        idle(2);

        for (int k = 1; k <= 3; k++) step(1, 0, DW'(k), 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, '0, 1, 0, 0, 0);
        idle(1);

        for (int k = 1; k <= 9; k++) step(1, 1, DW'(32'h100 + k), 0, 0, 0, 0);
        step(1, 1, 32'h1FF, 1, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1, 0);
        for (int k = 0; k < 9; k++) step(0, 0, '0, 1, 1, 0, 0);

        step(1, 0, 32'hAA, 1, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        step(0, 0, '0, 0, 0, 1, 0);

        for (int k = 0; k < 4; k++) step(1, 0, DW'(32'h50 + k), 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        step(1, 0, 32'hDEAD, 1, 0, 0, 1);
        idle(1);
        step(0, 0, '0, 1, 0, 0, 0);
        step(1, 1, 32'h77, 1, 1, 1, 0);

        for (int k = 0; k < 2000; k++) begin
            int phase;
            phase = (k / 100) % 3;
            step(($urandom_range(0, 3) < (phase == 0 ? 3 : (phase == 1 ? 1 : 2))),
                 int'($urandom_range(0, NC - 1)), $urandom(),
                 ($urandom_range(0, 3) < (phase == 0 ? 1 : (phase == 1 ? 3 : 2))),
                 int'($urandom_range(0, NC - 1)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
        end
        idle(2);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_fifo_target.md
# bus_fifo_target

Parametrised bus target that buffers writes into per-channel FIFOs and returns them on reads. It generalises the single-channel write/read bus: multiple channels, configurable data width and depth, registered read data with a valid strobe, and sticky overflow/underflow error flags. It sits directly on the bus interface as the DUT-side endpoint exercised by both the UVM bench and the formal properties.

## Interface

- DATA_WIDTH, 32, width of write_data/read_data
- DEPTH, 8, entries per channel FIFO; power of two, >= 2
- NUM_CHANNELS, 2, number of independent FIFOs; >= 1
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- write  input  1  push request
- write_channel  input  CH_W  target channel of push (CH_W = max(1, $clog2(NUM_CHANNELS)))
- write_data  input  DATA_WIDTH  push data
- read  input  1  pop request
- read_channel  input  CH_W  source channel of pop
- read_data  output  DATA_WIDTH  popped data, registered
- read_valid  output  1  one-cycle strobe qualifying read_data
- full  output  NUM_CHANNELS  per-channel full flag
- empty  output  NUM_CHANNELS  per-channel empty flag
- overflow  output  NUM_CHANNELS  sticky: write dropped on full channel
- underflow  output  NUM_CHANNELS  sticky: read on empty channel
- error_clear  input  1  clears all sticky flags

## Operation

- Reset (rst=1 at clk edge): all counts/pointers 0; read_data 0, read_valid 0, full all 0, empty all 1, overflow/underflow all 0. Reset wins over every other input in the same cycle.
- Channel index >= NUM_CHANNELS: request ignored, no flag set.
- Push accepted when write=1 and channel not full, or channel full and a read on the same channel is accepted in the same cycle (pass-through of a freed slot).
- Push on full without same-channel read: data dropped, overflow[ch] set.
- Pop accepted when read=1 and channel count > 0 at start of cycle; no bypass: write and read to the same empty channel in one cycle -> pop is underflow, push accepted.
- Pop on empty: underflow[ch] set, read_valid stays 0, read_data holds previous value.
- Write and read on different channels in the same cycle are independent.
- Per channel: wr_ptr, rd_ptr of $clog2(DEPTH) bits wrap modulo DEPTH; count of $clog2(DEPTH+1) bits; full = (count == DEPTH), empty = (count == 0).
- error_clear: clears all sticky flags; an error event in the same cycle takes priority (flag set).
- Data ordering strictly FIFO per channel.

## Timing

- Push: data visible for pop from next cycle; full/empty/count update next cycle.
- Pop: read_data and read_valid registered; valid 1 cycle after read accepted; read_valid high exactly one cycle per accepted pop.
- Back-to-back pops every cycle sustain one word per cycle.
- Sticky flags assert 1 cycle after the offending request; remain until error_clear or rst.

## Structure

- Package bus_fifo_pkg: helper function for CH_W computation, count/pointer width functions.
- Sub-module bus_fifo_channel: one FIFO (storage, pointers, count, full/empty, push/pop enables in, pop data out); instantiated NUM_CHANNELS times via generate.
- Top: request decode per channel, read data mux and output register, sticky flag registers.

## Test plan

- Reset then idle -> empty=2'b11, full=0, read_valid=0, read_data=0, flags 0.
- Write 0x1,0x2,0x3 to ch0, read ch0 x3 -> read_data 0x1,0x2,0x3 on three consecutive cycles after each read, read_valid high each; empty[0]=1 after.
- Write 9 words to ch1 (DEPTH=8) -> full[1]=1 after 8th, 9th dropped, overflow[1]=1; reads return words 1..8 only.
- Channel 1 full, write and read ch1 same cycle -> push accepted, no overflow, count stays 8, read returns oldest word.
- Read empty ch0 while writing ch0 0xAA -> underflow[0]=1, read_valid=0; next read returns 0xAA; error_clear -> underflow 0.
- Fill ch0 with 4 words, assert rst mid-stream with read=1 -> next cycle read_valid=0, empty[0]=1, subsequent read gives underflow.
